// File: rtl/radio_transceiver.sv
// Serial radio front-end: byte-wide controller port on a shared 8-bit bus, full-duplex
// 11-bit air frames (start, d0..d7 LSB first, even parity, stop) on tx_out / rx_in.

module radio_transceiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       radio_enable,
  input  logic       radio_send,
  input  logic       radio_receive,
  inout  wire  [7:0] radio_data,
  output logic       radio_busy,
  output logic       tx_out,
  input  logic       rx_in,
  output logic       rx_error
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } frame_state_e;

  frame_state_e     tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_idx_q;
  logic [7:0]       tx_shift_q;
  logic             tx_par_q;
  logic             tx_out_q;
  logic             tx_active_q;

  frame_state_e     rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_idx_q;
  logic [7:0]       rx_shift_q;
  logic             rx_par_err_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic             rx_valid_q;
  logic [7:0]       rx_buf_q;
  logic             rx_error_q;

  // Send and receive together is an illegal command and qualifies neither.
  logic cmd_send;
  logic cmd_recv;
  logic tx_accept;
  logic rx_consume;

  assign cmd_send   = radio_enable && radio_send && !radio_receive;
  assign cmd_recv   = radio_enable && radio_receive && !radio_send;
  assign tx_accept  = cmd_send && !tx_active_q;
  assign rx_consume = cmd_recv && rx_valid_q;

  assign radio_data = cmd_recv ? rx_buf_q : 8'bz;
  assign radio_busy = tx_active_q || (radio_enable && radio_receive && !rx_valid_q);
  assign tx_out     = tx_out_q;
  assign rx_error   = rx_error_q;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_out_q    <= 1'b1;
      tx_active_q <= 1'b0;
    end else if (tx_state_q == S_IDLE) begin
      if (tx_accept) begin
        tx_shift_q  <= radio_data;
        tx_par_q    <= ^radio_data;
        tx_out_q    <= 1'b0;
        tx_active_q <= 1'b1;
        tx_cnt_q    <= '0;
        tx_state_q  <= S_START;
      end
    end else if (tx_cnt_q != BIT_END) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end else begin
      // Bit period over: put the next bit on the line.
      tx_cnt_q <= '0;
      case (tx_state_q)
        S_START: begin
          tx_out_q   <= tx_shift_q[0];
          tx_idx_q   <= '0;
          tx_state_q <= S_DATA;
        end
        S_DATA: begin
          if (tx_idx_q == 3'd7) begin
            tx_out_q   <= tx_par_q;
            tx_state_q <= S_PARITY;
          end else begin
            tx_out_q   <= tx_shift_q[1];
            tx_shift_q <= tx_shift_q >> 1;
            tx_idx_q   <= tx_idx_q + 3'd1;
          end
        end
        S_PARITY: begin
          tx_out_q   <= 1'b1;
          tx_state_q <= S_STOP;
        end
        S_STOP: begin
          tx_active_q <= 1'b0;
          tx_state_q  <= S_IDLE;
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_err_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_buf_q     <= '0;
      rx_error_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_error_q <= 1'b0;
      if (rx_consume) rx_valid_q <= 1'b0;

      case (rx_state_q)
        S_IDLE: begin
          if (rx_prev_q && !rx_s_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          // Recheck the line at mid start bit to reject short glitches.
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= S_PARITY;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q     <= '0;
            rx_par_err_q <= rx_s_q ^ (^rx_shift_q);
            rx_state_q   <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            // A load in the same cycle as a consume wins; otherwise a full buffer is an overrun.
            if (!rx_s_q || rx_par_err_q || (rx_valid_q && !rx_consume)) begin
              rx_error_q <= 1'b1;
            end else begin
              rx_buf_q   <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radio_transceiver.sv
// Self-checking bench for radio_transceiver: frame-level reference model for the air side
// and a buffer/overrun model for the controller side.

module tb_radio_transceiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       send = 1'b0;
  logic       recv = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] drv_data = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] radio_data;
  logic       busy;
  logic       tx_out;
  logic       rx_error;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  logic       model_valid = 1'b0;
  logic [7:0] model_buf = 8'h00;
  int         model_errs = 0;

  assign radio_data = drv_en ? drv_data : 8'bz;

  radio_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .radio_enable (en),
    .radio_send   (send),
    .radio_receive(recv),
    .radio_data   (radio_data),
    .radio_busy   (busy),
    .tx_out       (tx_out),
    .rx_in        (rx_in),
    .rx_error     (rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_error === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Air-frame bits, index 0 = start bit, transmitted in index order.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = (^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic do_send(input logic [7:0] b, input logic [10:0] exp, input bit poke);
    en = 1'b1; send = 1'b1; recv = 1'b0; drv_en = 1'b1; drv_data = b;
    @(negedge clk);
    send = 1'b0; drv_en = 1'b0;
    for (int i = 0; i < 11 * CPB; i++) begin
      checks++;
      if (tx_out !== exp[i / CPB] || busy !== 1'b1) begin
        errors++;
        $display("FAIL tx_bit byte=%h cyc=%0d tx_out=%b busy=%b expected tx_out=%b busy=1",
                 b, i, tx_out, busy, exp[i / CPB]);
      end
      if (poke && i == 3 * CPB) begin
        send = 1'b1; drv_en = 1'b1; drv_data = ~b;
      end
      if (poke && i == 3 * CPB + 4) begin
        send = 1'b0; drv_en = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_end byte=%h tx_out=%b busy=%b expected tx_out=1 busy=0", b, tx_out, busy);
    end
  endtask

  task automatic inject(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, bad_stop);
    for (int k = 0; k < 11; k++) begin
      rx_in = bits[k];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (bad_par || bad_stop || model_valid) model_errs++;
    else begin
      model_valid = 1'b1;
      model_buf   = b;
    end
  endtask

  // Compares error pulses, then reads (and thereby consumes) any pending byte.
  task automatic check_rx_state(input string name);
    checks++;
    if (err_seen !== model_errs) begin
      errors++;
      $display("FAIL %s rx_error_pulses=%0d expected %0d", name, err_seen, model_errs);
    end
    en = 1'b1; recv = 1'b1; send = 1'b0;
    #1;
    checks++;
    if (model_valid) begin
      if (busy !== 1'b0 || radio_data !== model_buf) begin
        errors++;
        $display("FAIL %s read busy=%b data=%h expected busy=0 data=%h",
                 name, busy, radio_data, model_buf);
      end
    end else if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s empty busy=%b expected busy=1", name, busy);
    end
    @(negedge clk);
    model_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s after_consume busy=%b expected 1", name, busy);
    end
    recv = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || rx_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx_out=%b busy=%b rx_error=%b expected 1 0 0",
               tx_out, busy, rx_error);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_tx();
    en = 1'b1; send = 1'b1; drv_en = 1'b1; drv_data = 8'h00;
    @(negedge clk);
    send = 1'b0; drv_en = 1'b0;
    repeat (2 * CPB + 3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_tx_pre busy=%b tx_out=%b expected 1 0", busy, tx_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset busy=%b tx_out=%b expected 0 1", busy, tx_out);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_send(8'h3C, frame_bits(8'h3C, 1'b0, 1'b0), 1'b0);
  endtask

  task automatic test_send_a5();
    do_send(8'hA5, 11'b10101001010, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    do_send(a, frame_bits(a, 1'b0, 1'b0), 1'b0);
    do_send(b, frame_bits(b, 1'b0, 1'b0), 1'b1);
  endtask

  task automatic test_rx_good();
    inject(8'h5A, 1'b0, 1'b0);
    check_rx_state("rx_good");
  endtask

  task automatic test_rx_errors();
    inject(8'h01, 1'b1, 1'b0);
    inject(8'h02, 1'b0, 1'b1);
    rx_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rx_in = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_rx_state("rx_errors");
  endtask

  task automatic test_overrun();
    inject(8'h11, 1'b0, 1'b0);
    inject(8'h22, 1'b0, 1'b0);
    check_rx_state("overrun");
  endtask

  task automatic test_full_duplex();
    fork
      do_send(8'hC3, frame_bits(8'hC3, 1'b0, 1'b0), 1'b0);
      inject(8'h7E, 1'b0, 1'b0);
    join
    check_rx_state("full_duplex");
  endtask

  task automatic test_illegal();
    inject(8'h9C, 1'b0, 1'b0);
    en = 1'b1; send = 1'b1; recv = 1'b1; drv_en = 1'b1; drv_data = 8'h00;
    #1;
    checks++;
    if (radio_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_bus data=%h busy=%b expected 00 (undriven by dut) busy=0",
               radio_data, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_accept tx_out=%b busy=%b expected 1 0", tx_out, busy);
    end
    send = 1'b0; recv = 1'b0; en = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    check_rx_state("illegal_keep");
  endtask

  task automatic test_random_rx();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] b;
      int         mode;
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 3));
      inject(b, mode == 0, mode == 1);
      if ($urandom_range(0, 1) == 1) check_rx_state("random_rx");
    end
    check_rx_state("random_rx_final");
  endtask

  initial begin
    test_reset();
    test_reset_mid_tx();
    test_send_a5();
    test_back_to_back();
    test_rx_good();
    test_rx_errors();
    test_overrun();
    test_full_duplex();
    test_illegal();
    test_random_rx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radio_transceiver.md
# radio_transceiver

Serial radio front-end sitting directly downstream of the node controller's radio port. Accepts bytes to transmit and returns received bytes over the controller's shared 8-bit bidirectional `radio_data` bus, qualified by `radio_enable`/`radio_send`/`radio_receive` and paced by `radio_busy`. On the air side it runs full-duplex 11-bit frames on `tx_out`/`rx_in`: start(0), d0..d7 LSB first, even parity, stop(1).

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; even, ≥4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `radio_enable`  in  1  qualifies `radio_send`/`radio_receive`; does not abort frames in flight.
- `radio_send`  in  1  transmit request.
- `radio_receive`  in  1  receive request.
- `radio_data`  inout  8  driven with `rx_buf` only when `radio_enable && radio_receive && !radio_send`, else `8'bz`.
- `radio_busy`  out  1  `tx_active || (radio_enable && radio_receive && !rx_valid)`.
- `tx_out`  out  1  serial transmit line, idle 1.
- `rx_in`  in  1  serial receive line, asynchronous to `clk`.
- `rx_error`  out  1  one-cycle pulse on parity error, framing error, or overrun.

## Operation
- Reset (async assertion, sync release):
  - `tx_out`=1, `tx_active`=0, `rx_valid`=0, `rx_buf`=0, `rx_error`=0.
  - Both FSMs return to IDLE; the synchroniser flops are set to 1.
- TX FSM: IDLE -> START -> DATA(8) -> PARITY -> STOP -> IDLE.
  - Accept a byte at an edge where `radio_enable && radio_send && !radio_receive && !tx_active`. Latch `radio_data` and set `tx_active`.
  - A request while `tx_active`=1 is ignored; it is not queued.
  - Parity bit is the XOR of d0..d7.
  - `tx_active` clears at the end of STOP.
  - Dropping `radio_enable` or `radio_send` mid-frame does not affect the frame.
- RX FSM: IDLE -> START -> DATA(8) -> PARITY -> STOP -> IDLE.
  - `rx_in` passes through a 2-flop synchroniser (`rx_s`).
  - IDLE: a falling `rx_s` starts a half-bit counter. At `CLKS_PER_BIT/2`, if `rx_s`=0 go to DATA; otherwise treat it as a glitch and return to IDLE.
  - Later bits are sampled every `CLKS_PER_BIT` cycles from the start-bit midpoint.
  - STOP sample = 1 and parity OK: load `rx_buf` and set `rx_valid`.
  - Parity mismatch or STOP = 0: byte discarded, `rx_error` pulses.
  - Good frame arriving while `rx_valid`=1: new byte discarded, `rx_buf` kept, `rx_error` pulses.
  - RX runs regardless of `radio_enable`.
- Consume: at an edge where `radio_enable && radio_receive && !radio_send && rx_valid`, the controller samples `radio_data` and `rx_valid` clears.
  - If a new byte completes at the same edge, the load wins: `rx_valid` stays 1 and `rx_buf` takes the new byte.
- `radio_send && radio_receive` both high is an illegal command: nothing is accepted, nothing is consumed, the bus is not driven.
- TX and RX are independent; simultaneous transmit and receive is required to work.

## Timing
- Send accepted at edge N:
  - `tx_active`/`radio_busy`=1 and `tx_out`=0 from edge N+1.
  - Bit k (start=0) is held for edges N+1+k·CPB .. N+(k+1)·CPB.
  - `radio_busy` falls and `tx_out` returns to 1 at edge N+1+11·CPB.
  - Back-to-back sends: the earliest next accept is edge N+1+11·CPB.
- RX latency: `rx_valid` rises 2 cycles (synchroniser) + 10.5·CPB after the `rx_in` start-bit falling edge, ±1 cycle.
- `radio_busy` from the RX term is combinational on `radio_enable`, `radio_receive` and `rx_valid`. A byte is sampled at the same edge the controller sees `radio_busy`=0.
- `rx_error` is registered and high for exactly one cycle per event.

## Test plan
- Reset mid-TX-frame: `tx_out`=1, `radio_busy`=0 immediately, without waiting for a clock edge. After release, a new send of 8'h3C transmits cleanly.
- Send 8'hA5, CPB=16: `tx_out` = 0,1,0,1,0,0,1,0,1,0,1, each held 16 cycles. `radio_busy` is high for exactly 176 cycles. A second send during busy is ignored.
- Inject frame 8'h5A with good parity on `rx_in`:
  - `rx_valid`=1.
  - With receive+enable asserted, `radio_data`=8'h5A and `radio_busy`=0.
  - After consume, `rx_valid`=0 and `radio_busy`=1 while receive is still asserted.
- Inject 8'h01 with bad parity, then 8'h02 with stop=0: two `rx_error` pulses, `rx_valid` stays 0. A half-bit low glitch on `rx_in` causes no activity.
- Two good frames, 8'h11 then 8'h22, with no consume: `rx_buf`=8'h11 and one `rx_error` pulse. Consume returns 8'h11.
- Full duplex: send 8'hC3 while receiving 8'h7E. Both complete correctly. `radio_send` and `radio_receive` high together leaves `radio_data`=Z and accepts nothing.
